// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass and load-use hazard detection.
// Stalls refresh the captured operands with their forwarded values so bypassed data is kept.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_alufun,
  input  logic        id_sign,
  input  logic        id_alusrc1,
  input  logic        id_alusrc2,
  input  logic        id_uses_rt,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_dst,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_dst,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic [31:0] store_data,
  output logic [4:0]  ex_dst,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        load_use_hazard
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  alufun;
    logic        sign;
    logic        alusrc1;
    logic        alusrc2;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } stage_t;

  stage_t st_q, st_d;
  logic [31:0] fwd_rs, fwd_rt;

  // EX/MEM is the younger producer, so it is checked first; register 0 is never bypassed.
  function automatic logic [31:0] fwd_sel(input logic [4:0] r, input logic [31:0] d,
                                          input logic em_we, input logic [4:0] em_dst,
                                          input logic [31:0] em_res, input logic mw_we,
                                          input logic [4:0] mw_dst, input logic [31:0] mw_res);
    if (FWD_EN && em_we && (em_dst != 5'd0) && (em_dst == r)) return em_res;
    if (FWD_EN && mw_we && (mw_dst != 5'd0) && (mw_dst == r)) return mw_res;
    return d;
  endfunction

  always_comb begin
    fwd_rs = fwd_sel(st_q.rs, st_q.rs_data, exmem_regwrite, exmem_dst, exmem_result,
                     memwb_regwrite, memwb_dst, memwb_result);
    fwd_rt = fwd_sel(st_q.rt, st_q.rt_data, exmem_regwrite, exmem_dst, exmem_result,
                     memwb_regwrite, memwb_dst, memwb_result);
  end

  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else if (stall) begin
      st_d.rs_data = fwd_rs;
      st_d.rt_data = fwd_rt;
    end else begin
      st_d.valid    = id_valid;
      st_d.rs       = id_rs;
      st_d.rt       = id_rt;
      st_d.dst      = id_dst;
      st_d.rs_data  = id_rs_data;
      st_d.rt_data  = id_rt_data;
      st_d.imm      = id_imm;
      st_d.shamt    = id_shamt;
      st_d.alufun   = id_alufun;
      st_d.sign     = id_sign;
      st_d.alusrc1  = id_alusrc1;
      st_d.alusrc2  = id_alusrc2;
      st_d.regwrite = id_regwrite & id_valid;
      st_d.memread  = id_memread & id_valid;
      st_d.memwrite = id_memwrite & id_valid;
      st_d.memtoreg = id_memtoreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

  always_comb begin
    alu_a       = st_q.alusrc1 ? {27'b0, st_q.shamt} : fwd_rs;
    alu_b       = st_q.alusrc2 ? st_q.imm : fwd_rt;
    store_data  = fwd_rt;
    alu_fun     = st_q.alufun;
    alu_sign    = st_q.sign;
    ex_dst      = st_q.dst;
    ex_valid    = st_q.valid;
    ex_regwrite = st_q.regwrite;
    ex_memread  = st_q.memread;
    ex_memwrite = st_q.memwrite;
    ex_memtoreg = st_q.memtoreg;
  end

  assign load_use_hazard = st_q.valid & st_q.memread & (st_q.dst != 5'd0) &
                           id_valid & ((id_rs == st_q.dst) |
                                       (id_uses_rt & (id_rt == st_q.dst)));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run against a
// behavioural model of the stored instruction.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_dst, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_alufun;
  logic        id_sign, id_alusrc1, id_alusrc2, id_uses_rt;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_dst, memwb_dst;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, store_data;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [4:0]  ex_dst;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt), .id_alufun(id_alufun),
    .id_sign(id_sign), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .store_data(store_data), .ex_dst(ex_dst), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .load_use_hazard(load_use_hazard)
  );

  // Model: the instruction currently sitting in EX, as plain fields.
  typedef struct {
    bit          valid, sign, src1, src2, rw, mr, mw, mtr;
    bit [4:0]    rs, rt, dst, shamt;
    bit [31:0]   rsd, rtd, imm;
    bit [5:0]    fun;
  } ex_t;
  ex_t m;

  function automatic bit [31:0] value_of(input bit [4:0] r, input bit [31:0] held);
    if (r == 0) return held;
    if (exmem_regwrite && exmem_dst == r) return exmem_result;
    if (memwb_regwrite && memwb_dst == r) return memwb_result;
    return held;
  endfunction

  function automatic bit [113:0] expected_outputs();
    bit [31:0] a, b, sd;
    bit haz;
    sd  = value_of(m.rt, m.rtd);
    a   = m.src1 ? 32'(m.shamt) : value_of(m.rs, m.rsd);
    b   = m.src2 ? m.imm : sd;
    haz = m.valid && m.mr && m.dst != 0 && id_valid &&
          (id_rs == m.dst || (id_uses_rt && id_rt == m.dst));
    return {a, b, m.fun, m.sign, sd, m.dst, m.valid, m.rw, m.mr, m.mw, m.mtr, haz};
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = m;
    if (reset || flush) begin
      n = '{default: 0};
    end else if (stall) begin
      n.rsd = value_of(m.rs, m.rsd);
      n.rtd = value_of(m.rt, m.rtd);
    end else begin
      n.valid = id_valid;  n.rs = id_rs;  n.rt = id_rt;  n.dst = id_dst;
      n.rsd = id_rs_data;  n.rtd = id_rt_data;  n.imm = id_imm;  n.shamt = id_shamt;
      n.fun = id_alufun;  n.sign = id_sign;  n.src1 = id_alusrc1;  n.src2 = id_alusrc2;
      n.rw = id_valid && id_regwrite;  n.mr = id_valid && id_memread;
      n.mw = id_valid && id_memwrite;  n.mtr = id_memtoreg;
    end
    return n;
  endfunction

  function automatic bit [113:0] dut_outputs();
    return {alu_a, alu_b, alu_fun, alu_sign, store_data, ex_dst, ex_valid, ex_regwrite,
            ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard};
  endfunction

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alufun = 0; id_sign = 0;
    id_alusrc1 = 0; id_alusrc2 = 0; id_uses_rt = 0; id_regwrite = 0; id_memread = 0;
    id_memwrite = 0; id_memtoreg = 0; exmem_regwrite = 0; exmem_dst = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_dst = 0; memwb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_cmp++;
    if (dut_outputs() !== 114'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", dut_outputs());
    end
  endtask

  task automatic test_load_add();
    clear_inputs();
    id_valid = 1; id_rs = 3; id_rs_data = 5; id_rt = 4; id_rt_data = 7;
    id_regwrite = 1; id_alufun = 6'h20;
    tick();
    id_valid = 0;
    n_cmp++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || ex_valid !== 1'b1 || ex_regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL load_add: a=%h b=%h v=%b rw=%b want 5 7 1 1", alu_a, alu_b, ex_valid,
               ex_regwrite);
    end
  endtask

  task automatic test_forward_priority();
    exmem_regwrite = 1; exmem_dst = 3; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_dst = 3; memwb_result = 32'h22;
    #1;
    n_cmp++;
    if (alu_a !== 32'h11) begin
      n_fail++; $display("FAIL fwd_exmem_wins: got %h want 11", alu_a);
    end
    exmem_regwrite = 0;
    #1;
    n_cmp++;
    if (alu_a !== 32'h22) begin
      n_fail++; $display("FAIL fwd_memwb: got %h want 22", alu_a);
    end
    exmem_regwrite = 1; exmem_dst = 0; memwb_dst = 0;
    #1;
    n_cmp++;
    if (alu_a !== 32'd5) begin
      n_fail++; $display("FAIL fwd_dst0: got %h want 5", alu_a);
    end
    // Stored rs of 0 must never be replaced, even with a dst==0 producer present.
    clear_inputs();
    id_valid = 1; id_rs = 0; id_rs_data = 32'h9;
    tick();
    exmem_regwrite = 1; exmem_dst = 0; exmem_result = 32'hDEAD;
    #1;
    n_cmp++;
    if (alu_a !== 32'h9) begin
      n_fail++; $display("FAIL fwd_reg0: got %h want 9", alu_a);
    end
  endtask

  task automatic test_sll();
    clear_inputs();
    id_valid = 1; id_shamt = 4; id_alusrc1 = 1; id_rt = 6; id_rt_data = 0; id_uses_rt = 1;
    tick();
    memwb_regwrite = 1; memwb_dst = 6; memwb_result = 32'hA5;
    #1;
    n_cmp++;
    if (alu_a !== 32'd4 || alu_b !== 32'hA5 || store_data !== 32'hA5) begin
      n_fail++;
      $display("FAIL sll_fwd: a=%h b=%h sd=%h want 4 a5 a5", alu_a, alu_b, store_data);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_dst = 8; id_memread = 1; id_regwrite = 1; id_memtoreg = 1;
    tick();
    id_valid = 1; id_memread = 0; id_rs = 8; id_rt = 1;
    #1;
    n_cmp++;
    if (load_use_hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard_rs: got %b want 1", load_use_hazard);
    end
    id_rs = 9; id_rt = 8; id_uses_rt = 0;
    #1;
    n_cmp++;
    if (load_use_hazard !== 1'b0) begin
      n_fail++; $display("FAIL hazard_rt_unused: got %b want 0", load_use_hazard);
    end
    id_uses_rt = 1;
    #1;
    n_cmp++;
    if (load_use_hazard !== 1'b1) begin
      n_fail++; $display("FAIL hazard_rt: got %b want 1", load_use_hazard);
    end
    id_valid = 0;
    #1;
    n_cmp++;
    if (load_use_hazard !== 1'b0) begin
      n_fail++; $display("FAIL hazard_id_invalid: got %b want 0", load_use_hazard);
    end
  endtask

  task automatic test_stall_capture();
    clear_inputs();
    id_valid = 1; id_rs = 5; id_rs_data = 32'h1; id_regwrite = 1;
    tick();
    clear_inputs();
    stall = 1; memwb_regwrite = 1; memwb_dst = 5; memwb_result = 32'h33;
    tick();
    memwb_regwrite = 0;
    #1;
    n_cmp++;
    if (alu_a !== 32'h33 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_capture: a=%h v=%b want 33 1", alu_a, ex_valid);
    end
    tick();
    n_cmp++;
    if (alu_a !== 32'h33 || ex_regwrite !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: a=%h rw=%b want 33 1", alu_a, ex_regwrite);
    end
  endtask

  task automatic test_stall_flush_reset();
    clear_inputs();
    id_valid = 1; id_regwrite = 1; id_alufun = 6'h21; id_dst = 7; id_rs = 2; id_rs_data = 3;
    tick();
    stall = 1; flush = 1;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || alu_fun !== 6'd0 || ex_dst !== 5'd0) begin
      n_fail++;
      $display("FAIL stall_flush: v=%b rw=%b fun=%h dst=%0d want 0 0 0 0", ex_valid,
               ex_regwrite, alu_fun, ex_dst);
    end
    flush = 0; stall = 0; id_memread = 1;
    tick();
    stall = 1; reset = 1; id_valid = 0;
    tick();
    n_cmp++;
    if (dut_outputs() !== 114'd0) begin
      n_fail++; $display("FAIL reset_in_stall: got %h want 0", dut_outputs());
    end
    reset = 0; stall = 0; id_valid = 1; id_rs = 4; id_rs_data = 32'h44; id_memread = 0;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_a !== 32'h44 || ex_regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL load_after_reset: v=%b a=%h rw=%b want 1 44 1", ex_valid, alu_a,
               ex_regwrite);
    end
  endtask

  task automatic test_random();
    bit [113:0] exp_v;
    clear_inputs();
    reset = 1;
    tick();
    m = '{default: 0};
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = $urandom_range(0, 1);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_dst = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alufun = 6'($urandom); id_sign = 1'($urandom);
      id_alusrc1 = ($urandom_range(0, 3) == 0); id_alusrc2 = 1'($urandom);
      id_uses_rt = 1'($urandom); id_regwrite = 1'($urandom);
      id_memread = 1'($urandom); id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_dst = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_dst = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      #1;
      exp_v = expected_outputs();
      n_cmp++;
      if (dut_outputs() !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: got %h want %h", i, dut_outputs(), exp_v);
      end
      m = model_next();
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_add();
    test_forward_priority();
    test_sll();
    test_load_use();
    test_stall_capture();
    test_stall_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
